// File: rtl/lane_unstriping.sv
// Lane unstriping: 4-lane byte groups -> one byte per clk in lane order, with STP/END framing; optional UNSTRIPE_SKP_FILTER_EN drops idle-state SKP.
// Latency: lane 0 byte registered one edge after the push; backpressure: inReady low while the 2-group buffer is full.

module lane_unstriping_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module lane_unstriping (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TL0,
  input  logic [7:0] TL1,
  input  logic [7:0] TL2,
  input  logic [7:0] TL3,
  input  logic       inValid,
  output logic       inReady,
  output logic [7:0] toDemux,
  output logic       outValid,
  output logic       inPacket,
  output logic       frameErr
);
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] END = 8'hFD;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [31:0] head_dat;
  logic        full;
  logic        empty;
  logic        pop;
  logic [7:0]  lane_byte;
  logic [7:0]  dat_nxt;
  logic        vld_nxt;
  logic        pkt_nxt;
  logic        err_nxt;

  // Lane 0 sits in the low byte so the head group reads out LSB-first.
  lane_unstriping_fifo #(.W(32), .DEPTH(2)) u_grp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inValid),
    .push_dat ({TL3, TL2, TL1, TL0}),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  assign inReady   = !full;
  assign pop       = !empty && (idx == 2'd3);
  assign lane_byte = head_dat[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx      <= 2'd0;
      state    <= S_IDLE;
      toDemux  <= 8'h00;
      outValid <= 1'b0;
      inPacket <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      if (!empty) idx <= idx + 2'd1;
      state    <= state_nxt;
      toDemux  <= dat_nxt;
      outValid <= vld_nxt;
      inPacket <= pkt_nxt;
      frameErr <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dat_nxt   = toDemux;
    vld_nxt   = 1'b0;
    pkt_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (!empty) begin
      case (state)
        S_IDLE: begin
          if (lane_byte == STP) begin
            // A packet may only open on lane 0.
            if (idx == 2'd0) begin
              vld_nxt   = 1'b1;
              pkt_nxt   = 1'b1;
              dat_nxt   = lane_byte;
              state_nxt = S_PKT;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (lane_byte == IDL) begin
            vld_nxt = 1'b0;
          end else if (lane_byte == SKP) begin
`ifdef UNSTRIPE_SKP_FILTER_EN
            vld_nxt = 1'b0;
`else
            vld_nxt = 1'b1;
            dat_nxt = lane_byte;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
        S_PKT: begin
          if (lane_byte == STP) begin
            err_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            vld_nxt = 1'b1;
            pkt_nxt = 1'b1;
            dat_nxt = lane_byte;
            if (lane_byte == END) state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_unstriping.sv
// Directed bench for lane_unstriping: byte-queue reference model checked every cycle plus literal stream checks.
module tb_lane_unstriping;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] TL0, TL1, TL2, TL3;
  logic       inValid;
  logic       inReady;
  logic [7:0] toDemux;
  logic       outValid;
  logic       inPacket;
  logic       frameErr;

  int total = 0;
  int bad   = 0;

  lane_unstriping dut (
    .clk      (clk),
    .reset    (reset),
    .TL0      (TL0),
    .TL1      (TL1),
    .TL2      (TL2),
    .TL3      (TL3),
    .inValid  (inValid),
    .inReady  (inReady),
    .toDemux  (toDemux),
    .outValid (outValid),
    .inPacket (inPacket),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted bytes queued with their lane tag, consumed one per cycle.
  logic [9:0] mq[$];
  bit         m_pkt = 0;
  logic [7:0] e_dat = 8'h00;
  bit         e_ov = 0, e_ip = 0, e_fe = 0;

  task automatic model_step();
    bit         rdy;
    logic [9:0] ent;
    logic [7:0] b;
    if (reset) begin
      mq.delete();
      m_pkt = 0; e_dat = 8'h00; e_ov = 0; e_ip = 0; e_fe = 0;
      return;
    end
    rdy  = ((mq.size() + 3) / 4) < 2;
    e_ov = 0; e_ip = 0; e_fe = 0;
    if (mq.size() > 0) begin
      ent = mq.pop_front();
      b   = ent[7:0];
      if (!m_pkt) begin
        if (b == 8'hFB && ent[9:8] == 2'd0) begin
          e_ov = 1; e_ip = 1; e_dat = b; m_pkt = 1;
        end else if (b == 8'h7C) begin
          e_ov = 0;
        end else if (b == 8'h1C) begin
`ifndef UNSTRIPE_SKP_FILTER_EN
          e_ov = 1; e_dat = b;
`endif
        end else begin
          e_fe = 1;
        end
      end else begin
        if (b == 8'hFB) begin
          e_fe = 1; m_pkt = 0;
        end else begin
          e_ov = 1; e_ip = 1; e_dat = b;
          if (b == 8'hFD) m_pkt = 0;
        end
      end
    end
    if (inValid && rdy) begin
      mq.push_back({2'd0, TL0});
      mq.push_back({2'd1, TL1});
      mq.push_back({2'd2, TL2});
      mq.push_back({2'd3, TL3});
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle compare plus capture of interesting slots for the literal checks.
  bit          cap_en = 0;
  logic [10:0] cap_q[$];
  logic [10:0] exp_q[$];

  initial forever begin
    @(negedge clk);
    chk("toDemux",  32'(toDemux),  32'(e_dat));
    chk("outValid", 32'(outValid), 32'(e_ov));
    chk("inPacket", 32'(inPacket), 32'(e_ip));
    chk("frameErr", 32'(frameErr), 32'(e_fe));
    chk("inReady",  32'(inReady),  32'(((mq.size() + 3) / 4) < 2));
    if (cap_en && (outValid || frameErr))
      cap_q.push_back({frameErr, inPacket, outValid, outValid ? toDemux : 8'h00});
  end

  task automatic e(input bit fe, input bit ip, input bit ov, input logic [7:0] b);
    exp_q.push_back({fe, ip, ov, b});
  endtask

  task automatic check_seq(input string name);
    chk($sformatf("%s_len", name), 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_%0d", name, i), 32'(cap_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    cap_q.delete();
  endtask

  // g = {TL3,TL2,TL1,TL0}; returns #1 after the accepting edge with inValid still high.
  task automatic push(input logic [31:0] g, output int waits);
    bit r;
    TL0 = g[7:0]; TL1 = g[15:8]; TL2 = g[23:16]; TL3 = g[31:24];
    inValid = 1'b1;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = inReady;
      @(posedge clk);
      #1;
      if (r) break;
      waits++;
    end
    if (waits >= 20) begin
      total++; bad++;
      $display("FAIL push_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; inValid = 1'b0;
    TL0 = 8'h00; TL1 = 8'h00; TL2 = 8'h00; TL3 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_toDemux",  32'(toDemux),  32'h00);
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_inPacket", 32'(inPacket), 32'h0);
    chk("rst_frameErr", 32'(frameErr), 32'h0);
    chk("rst_inReady",  32'(inReady),  32'h1);
    reset = 1'b0;
    cap_en = 1'b1;
    idle(2);

    // SKP group in idle
    push(32'h1C1C1C1C, w);
    idle(7);
`ifndef UNSTRIPE_SKP_FILTER_EN
    repeat (4) e(0, 0, 1, 8'h1C);
`endif
    check_seq("skp");

    // Two-group packet back to back; lane 0 visible one edge after the push
    push(32'h030201FB, w);
    push(32'hFD060504, w);
    chk("lat_lane0_dat", 32'(toDemux),  32'hFB);
    chk("lat_lane0_vld", 32'(outValid), 32'h1);
    idle(10);
    e(0,1,1,8'hFB); e(0,1,1,8'h01); e(0,1,1,8'h02); e(0,1,1,8'h03);
    e(0,1,1,8'h04); e(0,1,1,8'h05); e(0,1,1,8'h06); e(0,1,1,8'hFD);
    check_seq("pkt2");

    // Three groups with inValid held: backpressure after the second accept
    push(32'h121110FB, w);
    push(32'h16151413, w);
    chk("full_inReady", 32'(inReady), 32'h0);
    push(32'hFD191817, w);
    chk("third_waits", 32'(w), 32'd3);
    idle(16);
    e(0,1,1,8'hFB); e(0,1,1,8'h10); e(0,1,1,8'h11); e(0,1,1,8'h12);
    e(0,1,1,8'h13); e(0,1,1,8'h14); e(0,1,1,8'h15); e(0,1,1,8'h16);
    e(0,1,1,8'h17); e(0,1,1,8'h18); e(0,1,1,8'h19); e(0,1,1,8'hFD);
    check_seq("bp3");

    // {7C,FB,01,FD}: STP off lane 0, then stray data and END in idle
    push(32'hFD01FB7C, w);
    idle(7);
    e(1,0,0,8'h00); e(1,0,0,8'h00); e(1,0,0,8'h00);
    check_seq("badstp");

    // {FB,01,FB,02}: nested STP aborts, trailing byte is an idle error
    push(32'h02FB01FB, w);
    idle(7);
    e(0,1,1,8'hFB); e(0,1,1,8'h01); e(1,0,0,8'h00); e(1,0,0,8'h00);
    check_seq("abort");

    // Asynchronous reset mid-packet
    push(32'h030201FB, w);
    push(32'h07060504, w);
    inValid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_dat",     32'(toDemux), 32'h01);
    chk("pre_rst_inReady", 32'(inReady), 32'h0);
    #2 reset = 1'b1;
    #1;
    chk("arst_toDemux",  32'(toDemux),  32'h00);
    chk("arst_outValid", 32'(outValid), 32'h0);
    chk("arst_inPacket", 32'(inPacket), 32'h0);
    chk("arst_frameErr", 32'(frameErr), 32'h0);
    chk("arst_inReady",  32'(inReady),  32'h1);
    @(posedge clk);
    #3 reset = 1'b0;
    cap_q.delete();
    @(posedge clk);
    #1;
    push(32'hFDBBAAFB, w);
    idle(7);
    e(0,1,1,8'hFB); e(0,1,1,8'hAA); e(0,1,1,8'hBB); e(0,1,1,8'hFD);
    check_seq("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
